fp16_div_seq: RTL and testbench
===============================

// Module: fp16_div_seq
// PURPOSE
//  Sequential IEEE-754 half-precision divider: out = a / b.
//  - Radix-2 restoring mantissa division, one quotient bit per cycle, round-to-nearest-even.
//  - Complements the combinational LUT/Newton-Raphson reciprocal: exact, correctly rounded,
//    small area. Sits behind a valid/ready stream in the fp16 datapath.
// PARAMETERS
//  QBITS  13  quotient bits produced: 1 integer + 10 fraction + guard + round; fixed, do not override
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   operands valid
//  in_ready   out  1   block can accept operands
//  in_a       in   16  fp16 dividend
//  in_b       in   16  fp16 divisor
//  out_valid  out  1   result valid; held until accepted
//  out_ready  in   1   consumer accepts result
//  out_data   out  16  fp16 quotient
//  out_flags  out  4   {invalid, div_by_zero, overflow, underflow}
// BEHAVIOUR
//  Reset (rst high at an edge) -> state IDLE; out_valid=0, out_data=0, out_flags=0.
//  - in_ready=0 while rst is high.
//  - Reset mid-operation abandons the operation; no result is ever emitted for it.
//  States and transitions:
//  - IDLE: in_ready=1, no other state. Accept on in_valid&in_ready.
//      special operand -> DONE; otherwise -> DIV.
//  - DIV: 13 cycles, bit counter 12..0; -> RND when counter hits 0.
//  - RND: 1 cycle; -> DONE.
//  - DONE: out_valid=1, out_data/out_flags stable; -> IDLE on out_ready.
//  Latency: out_valid rises 1 cycle after accept for special operands, 15 cycles otherwise.
//  - No overlap between operations; next accept no earlier than the cycle after the
//    out_valid&out_ready handshake.
//  Operand decode:
//  - Subnormal inputs (exp=0) are treated as signed zero (DAZ).
//  - sign = a.s ^ b.s for every result, including 0 and inf.
//  Special cases, checked in priority order:
//  - a or b NaN, 0/0, inf/inf -> 16'h7C01, invalid=1.
//  - inf/x -> {sign,7C00}.
//  - finite/0 -> {sign,7C00}, div_by_zero=1.
//  - 0/x or x/inf -> {sign,0000}.
//  Normal path:
//  - ma={1,a.man}, mb={1,b.man}; 7-bit signed exponent e = a.exp - b.exp + 15.
//  - At accept, if ma<mb: dividend = ma<<1 and e = e-1, so the quotient lies in [1,2).
//  - Each DIV cycle: rem<<=1 before the compare (i.e. rem=2*rem for bits after the first);
//    if rem>=mb then { rem-=mb; q_bit=1 } else q_bit=0.
//  - sticky = (final rem != 0).
//  - RND: G=q[1], R=q[0]; round up when G & (R | sticky | q[2]).
//  - Mantissa carry-out on round -> shift right, e+1.
//  - e>=31 -> {sign,7C00}, overflow=1.
//  - e<=0 -> {sign,0000}, underflow=1 (FTZ, no subnormal output).
//  - else {sign, e[4:0], q[11:2] rounded}.
//  - out_flags=0 for normal results.
//  Simultaneous events:
//  - rst overrides everything.
//  - in_valid while busy is ignored (in_ready=0); operands are not captured.
// TESTING
//  - 3C00/4000 -> 3800, flags 0, out_valid exactly 15 cycles after accept.
//  - 3C00/4200 -> 3555 (1/3 rounds down); 3C00/3E00 -> 3955.
//  - 0000/0000 -> 7C01 invalid; C000/0000 -> FC00 div_by_zero; 7C00/3C00 -> 7C00;
//    each with 1-cycle latency.
//  - 7BFF/0400 -> 7C00 overflow=1; 0400/7BFF -> 0000 underflow=1.
//  - out_ready held 0 for 10 cycles: out_data/out_flags stable, in_ready=0 throughout;
//    accept resumes the cycle after the handshake.
//  - rst pulsed during DIV cycle 5: no out_valid afterwards; in_ready=1 the cycle after rst
//    falls; the next op (3C00/4000) gives 3800 correctly.

Source files
------------

// File: rtl/fp16_div_seq.sv
// Sequential fp16 divider: restoring radix-2 mantissa division, one quotient bit
// per cycle, round-to-nearest-even, DAZ inputs and FTZ outputs.
module fp16_div_seq #(
    parameter int QBITS = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_flags
);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_RND, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [12:0]        rem_q, rem_d;
    logic [10:0]        mb_q, mb_d;
    logic [QBITS-1:0]   quo_q, quo_d;
    logic signed [6:0]  e_q, e_d;
    logic               sign_q, sign_d;
    logic [15:0]        data_q, data_d;
    logic [3:0]         flags_q, flags_d;

    logic [4:0]  a_exp, b_exp;
    logic [10:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    logic [6:0]  e_acc;
    logic [12:0] diff;
    logic        ge, rnd_up, carry;
    logic [11:0] mant_r;
    logic signed [6:0] e_f;
    logic [9:0]  man_f;

    assign a_exp  = in_a[14:10];
    assign b_exp  = in_b[14:10];
    assign ma     = {1'b1, in_a[9:0]};
    assign mb     = {1'b1, in_b[9:0]};
    // exp==0 covers subnormals too: they are flushed to zero on input
    assign a_zero = (a_exp == 5'd0);
    assign b_zero = (b_exp == 5'd0);
    assign a_inf  = (a_exp == 5'd31) && (in_a[9:0] == 10'd0);
    assign b_inf  = (b_exp == 5'd31) && (in_b[9:0] == 10'd0);
    assign a_nan  = (a_exp == 5'd31) && (in_a[9:0] != 10'd0);
    assign b_nan  = (b_exp == 5'd31) && (in_b[9:0] != 10'd0);
    assign sgn    = in_a[15] ^ in_b[15];
    // Pre-normalise so the quotient lands in [1,2); exponent wraps as 7-bit two's complement
    assign e_acc  = {2'b00, a_exp} - {2'b00, b_exp} + 7'd15 - ((ma < mb) ? 7'd1 : 7'd0);

    assign diff   = rem_q - {2'b00, mb_q};
    assign ge     = (rem_q >= {2'b00, mb_q});

    assign rnd_up = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
    assign mant_r = {1'b0, quo_q[12:2]} + {11'd0, rnd_up};
    assign carry  = mant_r[11];
    assign e_f    = carry ? e_q + 7'sd1 : e_q;
    assign man_f  = carry ? mant_r[10:1] : mant_r[9:0];

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;
    assign out_flags = flags_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        mb_d    = mb_q;
        quo_d   = quo_q;
        e_d     = e_q;
        sign_d  = sign_q;
        data_d  = data_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d  = sgn;
                    flags_d = 4'b0000;
                    state_d = S_DONE;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        data_d  = 16'h7C01;
                        flags_d = 4'b1000;
                    end else if (a_inf) begin
                        data_d = {sgn, 15'h7C00};
                    end else if (b_zero) begin
                        data_d  = {sgn, 15'h7C00};
                        flags_d = 4'b0100;
                    end else if (a_zero || b_inf) begin
                        data_d = {sgn, 15'h0000};
                    end else begin
                        mb_d    = mb;
                        rem_d   = (ma < mb) ? {1'b0, ma, 1'b0} : {2'b00, ma};
                        e_d     = $signed(e_acc);
                        cnt_d   = 4'(QBITS - 1);
                        quo_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                // Remainder is kept pre-shifted for the next bit; it stays below 2*mb
                if (ge) rem_d = {diff[11:0], 1'b0};
                else    rem_d = {rem_q[11:0], 1'b0};
                quo_d = {quo_q[QBITS-2:0], ge};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = S_RND;
            end
            S_RND: begin
                state_d = S_DONE;
                if (e_f >= 7'sd31) begin
                    data_d  = {sign_q, 15'h7C00};
                    flags_d = 4'b0010;
                end else if (e_f <= 7'sd0) begin
                    data_d  = {sign_q, 15'h0000};
                    flags_d = 4'b0001;
                end else begin
                    data_d = {sign_q, e_f[4:0], man_f};
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            mb_q    <= '0;
            quo_q   <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            data_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            mb_q    <= mb_d;
            quo_q   <= quo_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed bench for fp16_div_seq: hand-computed quotients, flags, latency,
// backpressure and mid-operation reset.
module tb_fp16_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_flags;

    int checks = 0;
    int failures = 0;

    fp16_div_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation; optionally stall the result for 'hold' cycles with
    // junk operands presented, then hand-shake and confirm accept resumes.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic [3:0] exp_f,
                         input int exp_lat, input int hold);
        int lat;
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        chk({tag, ".ready"}, in_ready, 1);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".data"}, out_data, exp_d);
        chk({tag, ".flags"}, out_flags, exp_f);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = 16'h4400; in_b = 16'h3C00;
            @(negedge clk);
            chk({tag, ".hold_vld"}, out_valid, 1);
            chk({tag, ".hold_data"}, out_data, exp_d);
            chk({tag, ".hold_flags"}, out_flags, exp_f);
            chk({tag, ".hold_rdy"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".vld_drop"}, out_valid, 0);
        chk({tag, ".rdy_back"}, in_ready, 1);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.out_flags", out_flags, 0);
        rst = 1'b0;

        do_op("1/2",      16'h3C00, 16'h4000, 16'h3800, 4'h0, 15, 0);
        do_op("1/3",      16'h3C00, 16'h4200, 16'h3555, 4'h0, 15, 0);
        do_op("1/1.5",    16'h3C00, 16'h3E00, 16'h3955, 4'h0, 15, 0);
        do_op("1.25/1.75",16'h3D00, 16'h3F00, 16'h39B7, 4'h0, 15, 0);
        do_op("1/1.001",  16'h3C00, 16'h3C01, 16'h3BFE, 4'h0, 15, 0);
        do_op("0/0",      16'h0000, 16'h0000, 16'h7C01, 4'h8, 1, 0);
        do_op("-2/0",     16'hC000, 16'h0000, 16'hFC00, 4'h4, 1, 0);
        do_op("inf/1",    16'h7C00, 16'h3C00, 16'h7C00, 4'h0, 1, 0);
        do_op("nan/1",    16'h7E00, 16'h3C00, 16'h7C01, 4'h8, 1, 0);
        do_op("inf/inf",  16'hFC00, 16'h7C00, 16'h7C01, 4'h8, 1, 0);
        do_op("-0/2",     16'h8000, 16'h4000, 16'h8000, 4'h0, 1, 0);
        do_op("1/-inf",   16'h3C00, 16'hFC00, 16'h8000, 4'h0, 1, 0);
        do_op("sub/1",    16'h0001, 16'h3C00, 16'h0000, 4'h0, 1, 0);
        do_op("1/sub",    16'h3C00, 16'h8001, 16'hFC00, 4'h4, 1, 0);
        do_op("ovf",      16'h7BFF, 16'h0400, 16'h7C00, 4'h2, 15, 0);
        do_op("unf",      16'h0400, 16'h7BFF, 16'h0000, 4'h1, 15, 0);
        do_op("stall",    16'h3C00, 16'h4200, 16'h3555, 4'h0, 15, 10);
        do_op("post",     16'h3C00, 16'h4000, 16'h3800, 4'h0, 15, 0);

        // Reset during the fifth DIV cycle abandons the operation
        @(negedge clk);
        in_a = 16'h3C00; in_b = 16'h4000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst.rdy_low", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst.rdy_back", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mrst.no_result", seen, 0);
        do_op("mrst.next", 16'h3C00, 16'h4000, 16'h3800, 4'h0, 15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
